// File: rtl/ycr1_sleep_ctrl.sv
// WFI sleep/wake sequencer on the always-on clock; drives the clock controller's sleep/wake requests.
// Outputs are pure flop decodes (abort is a registered pulse); there is no backpressure, and clk_en_i feedback paces the handshake.
module ycr1_sleep_ctrl #(
    parameter int unsigned SLEEP_DLY = 4,
    parameter int unsigned DRAIN_TMO = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       ctrl_rst_n,
    input  logic       wfi_req_i,
    input  logic       pipe_idle_i,
    input  logic       irq_pend_i,
    input  logic       dbg_req_i,
    input  logic       clk_en_i,
    output logic       sleep_req_o,
    output logic       wake_req_o,
    output logic       wfi_halted_o,
    output logic       wfi_abort_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_REQ   = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SLEEP_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DRAIN_TMO - 1);

    // Raw 3-bit flop so the unused codes 5..7 are representable and recoverable.
    logic [2:0]       state_q;
    state_e           state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             abort_q, abort_d;
    logic             wake_evt;

    assign wake_evt = irq_pend_i | dbg_req_i;

    always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = ST_RUN;
        idle_cnt_d = idle_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        abort_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (wfi_req_i && !wake_evt) begin
                    state_d    = ST_DRAIN;
                    idle_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                idle_cnt_d = pipe_idle_i ? idle_cnt_q + CNT_W'(1) : '0;
                tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
                // Wake beats idle-complete, which beats timeout.
                if (wake_evt) begin
                    state_d = ST_RUN;
                    abort_d = 1'b1;
                end else if (pipe_idle_i && (idle_cnt_q == IDLE_LAST)) begin
                    state_d = ST_REQ;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_RUN;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_REQ: begin
                if (wake_evt)       state_d = ST_WAKE;
                else if (!clk_en_i) state_d = ST_SLEEP;
                else                state_d = ST_REQ;
            end
            ST_SLEEP: begin
                state_d = wake_evt ? ST_WAKE : ST_SLEEP;
            end
            ST_WAKE: begin
                state_d = clk_en_i ? ST_RUN : ST_WAKE;
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                tmo_cnt_d  = '0;
            end
        endcase
    end

    assign sleep_req_o  = (state_q == ST_REQ);
    assign wake_req_o   = (state_q == ST_WAKE);
    assign wfi_halted_o = (state_q == ST_REQ) || (state_q == ST_SLEEP) || (state_q == ST_WAKE);
    assign wfi_abort_o  = abort_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ycr1_sleep_ctrl.sv
// Scoreboard bench for ycr1_sleep_ctrl with a simple clock-controller model driving clk_en_i.
module tb_ycr1_sleep_ctrl;

    logic       clk = 1'b0;
    logic       ctrl_rst_n;
    logic       wfi_req_i, pipe_idle_i, irq_pend_i, dbg_req_i, clk_en_i;
    logic       sleep_req_o, wake_req_o, wfi_halted_o, wfi_abort_o;
    logic [2:0] state_o;

    logic       cc_hold;
    int         cyc = 0;
    int         base = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        int         due;
        string      nm;
        logic [2:0] st;
        logic       ab;
    } exp_t;

    exp_t sb[$];

    ycr1_sleep_ctrl dut (
        .clk          (clk),
        .ctrl_rst_n   (ctrl_rst_n),
        .wfi_req_i    (wfi_req_i),
        .pipe_idle_i  (pipe_idle_i),
        .irq_pend_i   (irq_pend_i),
        .dbg_req_i    (dbg_req_i),
        .clk_en_i     (clk_en_i),
        .sleep_req_o  (sleep_req_o),
        .wake_req_o   (wake_req_o),
        .wfi_halted_o (wfi_halted_o),
        .wfi_abort_o  (wfi_abort_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Clock controller: disables on sleep request, re-enables on wake request unless held off.
    always @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n)                  clk_en_i <= 1'b1;
        else if (sleep_req_o)             clk_en_i <= 1'b0;
        else if (wake_req_o && !cc_hold)  clk_en_i <= 1'b1;
    end

    // Monitor: checks exclusivity every cycle and pops expectations due this cycle.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] exp_v, act_v;
        n_chk++;
        if (sleep_req_o && wake_req_o) begin
            n_fail++;
            $display("FAIL excl cyc=%0d sleep_req_o=%b wake_req_o=%b required not both high",
                     cyc, sleep_req_o, wake_req_o);
        end
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.due < cyc) begin
                n_fail++;
                $display("FAIL %s missed: due cyc %0d, seen at %0d", e.nm, e.due, cyc);
            end else begin
                exp_v = {e.st, (e.st == 3'd2), (e.st == 3'd4),
                         (e.st == 3'd2 || e.st == 3'd3 || e.st == 3'd4), e.ab};
                act_v = {state_o, sleep_req_o, wake_req_o, wfi_halted_o, wfi_abort_o};
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d {state,sleep,wake,halted,abort} got %b_%b%b%b%b want %b_%b%b%b%b",
                             e.nm, cyc, act_v[7:5], act_v[4], act_v[3], act_v[2], act_v[1],
                             exp_v[7:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1]);
                end
            end
        end
    end

    function automatic void push(int rel, string nm, logic [2:0] st, logic ab);
        exp_t e;
        e.due = base + rel;
        e.nm  = nm;
        e.st  = st;
        e.ab  = ab;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(int rel);
        while (cyc < base + rel) tick();
    endtask

    task automatic next_test();
        tick();
        tick();
        base = cyc;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        ctrl_rst_n  = 1'b0;
        wfi_req_i   = 1'b0;
        pipe_idle_i = 1'b0;
        irq_pend_i  = 1'b0;
        dbg_req_i   = 1'b0;
        cc_hold     = 1'b0;

        // Reset values
        base = 0;
        push(1, "rst_a", 3'd0, 1'b0);
        push(2, "rst_b", 3'd0, 1'b0);
        go(3);
        ctrl_rst_n = 1'b1;

        // Full sleep/wake; WFI pulses in SLEEP and WAKE are ignored
        next_test();
        push(0,  "A_run0",   3'd0, 1'b0);
        push(1,  "A_drain1", 3'd1, 1'b0);
        push(4,  "A_drain4", 3'd1, 1'b0);
        push(5,  "A_req5",   3'd2, 1'b0);
        push(6,  "A_req6",   3'd2, 1'b0);
        push(7,  "A_sleep7", 3'd3, 1'b0);
        push(11, "A_slp_wfi",3'd3, 1'b0);
        push(12, "A_slp12",  3'd3, 1'b0);
        push(20, "A_sleep20",3'd3, 1'b0);
        push(21, "A_wake21", 3'd4, 1'b0);
        push(22, "A_wake22", 3'd4, 1'b0);
        push(23, "A_run23",  3'd0, 1'b0);
        pipe_idle_i = 1'b1;
        wfi_req_i   = 1'b1;
        go(1);  wfi_req_i = 1'b0;
        go(10); wfi_req_i = 1'b1;
        go(11); wfi_req_i = 1'b0;
        go(20); irq_pend_i = 1'b1;
        go(21); irq_pend_i = 1'b0; wfi_req_i = 1'b1;
        go(22); wfi_req_i = 1'b0;
        go(23);

        // Reset mid-SLEEP, then a fresh WFI
        next_test();
        push(7,  "B_sleep7",  3'd3, 1'b0);
        push(8,  "B_sleep8",  3'd3, 1'b0);
        push(9,  "B_rst_imm", 3'd0, 1'b0);
        push(10, "B_rst_hold",3'd0, 1'b0);
        push(15, "B_drain",   3'd1, 1'b0);
        push(16, "B_req",     3'd2, 1'b0);
        push(18, "B_sleep",   3'd3, 1'b0);
        push(20, "B_wake",    3'd4, 1'b0);
        push(22, "B_run",     3'd0, 1'b0);
        pipe_idle_i = 1'b1;
        wfi_req_i   = 1'b1;
        go(1);  wfi_req_i = 1'b0;
        go(9);  ctrl_rst_n = 1'b0;
        go(10); ctrl_rst_n = 1'b1;
        go(11); wfi_req_i = 1'b1;
        go(12); wfi_req_i = 1'b0;
        go(19); irq_pend_i = 1'b1;
        go(20); irq_pend_i = 1'b0;
        go(22);
        pipe_idle_i = 1'b0;

        // WFI with wake event in the same cycle acts as a NOP
        next_test();
        push(1, "C_nop1", 3'd0, 1'b0);
        push(2, "C_nop2", 3'd0, 1'b0);
        wfi_req_i  = 1'b1;
        irq_pend_i = 1'b1;
        go(1); wfi_req_i = 1'b0; irq_pend_i = 1'b0;
        go(2);

        // DRAIN timeout with pipe_idle toggling 1,1,1,0
        next_test();
        push(1,  "D_drain1",  3'd1, 1'b0);
        push(30, "D_drain30", 3'd1, 1'b0);
        push(64, "D_drain64", 3'd1, 1'b0);
        push(65, "D_abort",   3'd0, 1'b1);
        push(66, "D_abort_end", 3'd0, 1'b0);
        wfi_req_i = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            go(k);
            wfi_req_i   = 1'b0;
            pipe_idle_i = ((k - 1) % 4) != 3;
        end
        go(65); pipe_idle_i = 1'b0;
        go(66);

        // Debug request abandons DRAIN
        next_test();
        push(10, "E_drain10", 3'd1, 1'b0);
        push(11, "E_abort",   3'd0, 1'b1);
        push(12, "E_abort_end", 3'd0, 1'b0);
        wfi_req_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            go(k);
            wfi_req_i   = 1'b0;
            pipe_idle_i = ((k - 1) % 4) != 3;
        end
        dbg_req_i = 1'b1;
        go(11); dbg_req_i = 1'b0; pipe_idle_i = 1'b0;
        go(12);

        // Wake event in the REQ cycle with the clock held off for 3 cycles
        next_test();
        push(5,  "F_req",   3'd2, 1'b0);
        push(6,  "F_wake6", 3'd4, 1'b0);
        push(7,  "F_wake7", 3'd4, 1'b0);
        push(8,  "F_wake8", 3'd4, 1'b0);
        push(9,  "F_wake9", 3'd4, 1'b0);
        push(10, "F_run",   3'd0, 1'b0);
        cc_hold     = 1'b1;
        pipe_idle_i = 1'b1;
        wfi_req_i   = 1'b1;
        go(1); wfi_req_i = 1'b0;
        go(5); irq_pend_i = 1'b1;
        go(6); irq_pend_i = 1'b0;
        go(8); cc_hold = 1'b0;
        go(10);
        pipe_idle_i = 1'b0;

        // Illegal state encoding recovers to RUN
        next_test();
        push(1, "G_recover", 3'd0, 1'b0);
        push(2, "G_stay",    3'd0, 1'b0);
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        go(2);

        tick();
        tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
